// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp16_pkg
// Brief   : Shared FP16 constants, FSM state and operand-class types.
// Revision: 1.0
// ============================================================================
package fp16_pkg;

    localparam int FP16_W = 16;
    localparam int EXP_W  = 5;
    localparam int FRAC_W = 10;
    localparam int BIAS   = 15;
    localparam int SIG_W  = FRAC_W + 1;   // significand with hidden bit
    localparam int Q_W    = FRAC_W + 2;   // quotient bits produced

    localparam logic [FP16_W-1:0] INF  = 16'h7C00;
    localparam logic [FP16_W-1:0] QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,
        CLS_NORMAL = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } fp_class_t;

    // Subnormals classify as zero: they are flushed on input.
    function automatic fp_class_t fp16_classify(input logic [FP16_W-1:0] x);
        fp_class_t c;
        if (x[FP16_W-2:FRAC_W] == '0)
            c = CLS_ZERO;
        else if (x[FP16_W-2:FRAC_W] == '1)
            c = (x[FRAC_W-1:0] == '0) ? CLS_INF : CLS_NAN;
        else
            c = CLS_NORMAL;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp16_div_mant.sv
`default_nettype none
// ============================================================================
// Module  : fp16_div_mant
// Brief   : Restoring significand divider, one quotient bit per cycle.
// Revision: 1.0
// ============================================================================
module fp16_div_mant
    import fp16_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [SIG_W-1:0] i_a_sig,
    input  logic [SIG_W-1:0] i_d_sig,
    output logic             o_done,
    output logic [Q_W-1:0]   o_q
);

    logic [SIG_W:0]   r_rem;
    logic [SIG_W-1:0] r_div;
    logic [Q_W-1:0]   r_q;
    logic [3:0]       r_cnt;
    logic             r_busy;

    logic             w_ge;
    logic [SIG_W:0]   w_sub;
    logic [SIG_W:0]   w_rem_next;
    logic [Q_W-1:0]   w_q_next;

    assign w_ge       = (r_rem >= {1'b0, r_div});
    assign w_sub      = r_rem - {1'b0, r_div};
    assign w_rem_next = w_ge ? w_sub : r_rem;
    assign w_q_next   = r_q | ({{(Q_W-1){1'b0}}, w_ge} << r_cnt);

    // The final bit is folded in combinationally so the top can capture
    // the complete quotient on the same edge the last step retires.
    assign o_done = r_busy && (r_cnt == 4'd0);
    assign o_q    = w_q_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= {1'b0, i_a_sig};
            r_div  <= i_d_sig;
            r_q    <= '0;
            r_cnt  <= 4'(Q_W - 1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem <= w_rem_next << 1;
            r_q   <= w_q_next;
            if (r_cnt == 4'd0)
                r_busy <= 1'b0;
            else
                r_cnt <= r_cnt - 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp16_divider.sv
`default_nettype none
// ============================================================================
// Module  : fp16_divider
// Brief   : Iterative FP16 divider, truncating, fixed 13-cycle latency.
//           Define FP16_DIV_SPECIALS_EN for NaN/infinity operand handling.
// Revision: 1.0
// ============================================================================
module fp16_divider
    import fp16_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [FP16_W-1:0] io_a,
    input  logic [FP16_W-1:0] io_b,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [FP16_W-1:0] io_y
);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_sign;
    logic signed [6:0]  r_exp;
    logic               r_special;
    logic [FP16_W-1:0]  r_special_y;
    logic [FP16_W-1:0]  r_y;

    logic               w_accept;
    logic               w_sign;
    logic signed [6:0]  w_exp;
    fp_class_t          w_cls_a;
    fp_class_t          w_cls_b;
    logic               w_special;
    logic [FP16_W-1:0]  w_special_y;
    logic               w_mant_done;
    logic [Q_W-1:0]     w_q;
    logic signed [6:0]  w_exp_norm;
    logic [FRAC_W-1:0]  w_frac;
    logic [FP16_W-1:0]  w_result;

    assign w_accept = (r_state == IDLE) && io_in_valid;
    assign w_sign   = io_a[FP16_W-1] ^ io_b[FP16_W-1];
    assign w_exp    = $signed({2'b00, io_a[FP16_W-2:FRAC_W]})
                    - $signed({2'b00, io_b[FP16_W-2:FRAC_W]})
                    + 7'sd15;
    assign w_cls_a  = fp16_classify(io_a);
    assign w_cls_b  = fp16_classify(io_b);

    // Special outcomes are resolved at accept; the divider still runs so
    // every operand class sees the same latency.
    always_comb begin
        w_special   = 1'b0;
        w_special_y = '0;
`ifdef FP16_DIV_SPECIALS_EN
        if (w_cls_a == CLS_NAN || w_cls_b == CLS_NAN ||
            (w_cls_a == CLS_INF  && w_cls_b == CLS_INF) ||
            (w_cls_a == CLS_ZERO && w_cls_b == CLS_ZERO)) begin
            w_special   = 1'b1;
            w_special_y = QNAN;
        end else if (w_cls_a == CLS_INF) begin
            w_special   = 1'b1;
            w_special_y = {w_sign, INF[FP16_W-2:0]};
        end else if (w_cls_b == CLS_INF) begin
            w_special   = 1'b1;
            w_special_y = {w_sign, {(FP16_W-1){1'b0}}};
        end else
`endif
        if (w_cls_b == CLS_ZERO) begin
            w_special   = 1'b1;
            w_special_y = {w_sign, INF[FP16_W-2:0]};
        end else if (w_cls_a == CLS_ZERO) begin
            w_special   = 1'b1;
            w_special_y = {w_sign, {(FP16_W-1){1'b0}}};
        end
    end

    fp16_div_mant u_mant (
        .clk     (clock),
        .rst     (reset),
        .i_start (w_accept),
        .i_a_sig ({1'b1, io_a[FRAC_W-1:0]}),
        .i_d_sig ({1'b1, io_b[FRAC_W-1:0]}),
        .o_done  (w_mant_done),
        .o_q     (w_q)
    );

    assign w_exp_norm = w_q[Q_W-1] ? r_exp : (r_exp - 7'sd1);
    assign w_frac     = w_q[Q_W-1] ? w_q[Q_W-2:1] : w_q[FRAC_W-1:0];

    always_comb begin
        if (r_special)
            w_result = r_special_y;
        else if (w_exp_norm >= 7'sd31)
            w_result = {r_sign, INF[FP16_W-2:0]};
        else if (w_exp_norm <= 7'sd0)
            w_result = {r_sign, {(FP16_W-1){1'b0}}};
        else
            w_result = {r_sign, w_exp_norm[EXP_W-1:0], w_frac};
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (io_in_valid)  w_state_next = DIVIDE;
            DIVIDE:  if (w_mant_done)  w_state_next = DONE;
            DONE:    if (io_out_ready) w_state_next = IDLE;
            default:                   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_special   <= 1'b0;
            r_special_y <= '0;
            r_y         <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_sign      <= w_sign;
                r_exp       <= w_exp;
                r_special   <= w_special;
                r_special_y <= w_special_y;
            end
            if (w_mant_done)
                r_y <= w_result;
        end
    end

    assign io_in_ready  = (r_state == IDLE);
    assign io_out_valid = (r_state == DONE);
    assign io_y         = r_y;

endmodule
`default_nettype wire

// File: tb/tb_fp16_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp16_divider
// Brief   : Directed self-checking bench with an arithmetic reference model.
// Revision: 1.0
// ============================================================================
module tb_fp16_divider;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_in_valid = 1'b0;
    logic        io_out_ready = 1'b1;
    logic [15:0] io_a = '0;
    logic [15:0] io_b = '0;
    logic        io_in_ready;
    logic        io_out_valid;
    logic [15:0] io_y;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    fp16_divider dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_a         (io_a),
        .io_b         (io_b),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_y         (io_y)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference: exact integer quotient of the scaled significands.
    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, fa, fb, q, e;
        logic s;
        logic [9:0] frac;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        fa = int'(a[9:0]);
        fb = int'(b[9:0]);
`ifdef FP16_DIV_SPECIALS_EN
        if ((ea == 31 && fa != 0) || (eb == 31 && fb != 0)) return 16'h7E00;
        if (ea == 31 && eb == 31) return 16'h7E00;
        if (ea == 0 && eb == 0) return 16'h7E00;
        if (ea == 31) return {s, 15'h7C00};
        if (eb == 31) return {s, 15'h0000};
`endif
        if (eb == 0) return {s, 15'h7C00};
        if (ea == 0) return {s, 15'h0000};
        q = ((1024 + fa) * 2048) / (1024 + fb);
        e = ea - eb + 15;
        if (q >= 2048) begin
            frac = 10'((q >> 1) & 1023);
        end else begin
            frac = 10'(q & 1023);
            e = e - 1;
        end
        if (e >= 31) return {s, 15'h7C00};
        if (e <= 0) return {s, 15'h0000};
        return {s, e[4:0], frac};
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compare process: every accepted operation is predicted by the model
    // and matched against the output while it is valid.
    logic [15:0] exp_q[$];
    int          stamp_q[$];
    logic        prev_valid = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            stamp_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (io_out_valid) begin
                check_int("mon_in_ready_in_done", int'(io_in_ready), 0);
                if (exp_q.size() == 0) begin
                    check_int("mon_unexpected_output", 1, 0);
                end else begin
                    check16("mon_model_y", io_y, exp_q[0]);
                    if (!prev_valid)
                        check_int("mon_latency", cyc - stamp_q[0], 13);
                    if (io_out_ready) begin
                        void'(exp_q.pop_front());
                        void'(stamp_q.pop_front());
                    end
                end
            end
            if (io_in_valid && io_in_ready) begin
                exp_q.push_back(model(io_a, io_b));
                stamp_q.push_back(cyc);
            end
            prev_valid = io_out_valid;
        end
    end

    // Called at posedge+1; returns at posedge+1 in the cycle after the handshake.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_y, input string name,
                          input int hold, output int acc_cyc);
        int n;
        logic [15:0] y0;
        n = 0;
        while (!io_in_ready && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        acc_cyc = cyc;
        if (!io_in_ready) begin
            check_int({name, "_ready_timeout"}, 0, 1);
            return;
        end
        io_a = a;
        io_b = b;
        io_in_valid = 1'b1;
        io_out_ready = (hold == 0);
        @(posedge clock); #1;
        io_in_valid = 1'b0;
        io_a = 16'($urandom);
        io_b = 16'($urandom);
        n = 0;
        while (!io_out_valid && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        if (!io_out_valid) begin
            check_int({name, "_valid_timeout"}, 0, 1);
            io_out_ready = 1'b1;
            return;
        end
        check_int({name, "_latency"}, cyc - acc_cyc, 13);
        check16(name, io_y, exp_y);
        if (hold > 0) begin
            y0 = io_y;
            repeat (hold) begin
                @(posedge clock); #1;
                check_int({name, "_hold_valid"}, int'(io_out_valid), 1);
                check16({name, "_hold_y"}, io_y, y0);
                check_int({name, "_hold_in_ready"}, int'(io_in_ready), 0);
            end
            io_out_ready = 1'b1;
        end
        @(posedge clock); #1;
        check_int({name, "_ready_after"}, int'(io_in_ready), 1);
        check_int({name, "_valid_after"}, int'(io_out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2;
        #1 reset = 1'b1;
        #2;
        check_int("reset_in_ready", int'(io_in_ready), 1);
        check_int("reset_out_valid", int'(io_out_valid), 0);
        check16("reset_y", io_y, 16'h0000);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        check16("model_pin_third", model(16'h3C00, 16'h4200), 16'h3555);
        check16("model_pin_neg", model(16'hC600, 16'h4000), 16'hC200);
        check16("model_pin_ovf", model(16'h7BFF, 16'h0400), 16'h7C00);
        check16("model_pin_unf", model(16'h0400, 16'h7BFF), 16'h0000);

        run_op(16'h3C00, 16'h4200, 16'h3555, "one_third", 0, a0);
        run_op(16'hC600, 16'h4000, 16'hC200, "neg_six_half", 0, a1);
        run_op(16'h3C00, 16'h4000, 16'h3800, "one_half", 0, a2);
        check_int("issue_interval", a2 - a1, 14);

        run_op(16'h3C00, 16'h0000, 16'h7C00, "div_by_zero", 0, a0);
        run_op(16'h8000, 16'h4000, 16'h8000, "neg_zero_num", 0, a0);
        run_op(16'h7BFF, 16'h0400, 16'h7C00, "overflow", 0, a0);
        run_op(16'h0400, 16'h7BFF, 16'h0000, "underflow", 0, a0);
        run_op(16'h3C00, 16'h4000, 16'h3800, "backpressure", 5, a0);

        // Abort an operation partway through the iteration.
        io_a = 16'h3C00;
        io_b = 16'h4200;
        io_in_valid = 1'b1;
        @(posedge clock); #1;
        io_in_valid = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        #1;
        check_int("midreset_in_ready", int'(io_in_ready), 1);
        check_int("midreset_out_valid", int'(io_out_valid), 0);
        check16("midreset_y", io_y, 16'h0000);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        run_op(16'h4200, 16'h3E00, 16'h4000, "after_reset", 0, a0);

`ifdef FP16_DIV_SPECIALS_EN
        run_op(16'h7E00, 16'h3C00, 16'h7E00, "nan_operand", 0, a0);
        run_op(16'h7C00, 16'h7C00, 16'h7E00, "inf_over_inf", 0, a0);
        run_op(16'h0000, 16'h0000, 16'h7E00, "zero_over_zero", 0, a0);
        run_op(16'h8000, 16'h0000, 16'h7E00, "negzero_over_zero", 0, a0);
`else
        run_op(16'h0000, 16'h0000, 16'h7C00, "zero_over_zero", 0, a0);
        run_op(16'h8000, 16'h0000, 16'hFC00, "negzero_over_zero", 0, a0);
`endif

        repeat (3) @(posedge clock);
        check_int("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp16_divider.md
# fp16_divider

Iterative IEEE-754 binary16 divider: the inverse of the team's single-cycle FP16 multiplier. It takes a dividend and divisor through a valid/ready input port, computes sign, biased exponent and a 12-bit restoring-division quotient one bit per cycle, and presents a truncated FP16 result on a valid/ready output port. It sits beside the multiplier in the Chisel-generated arithmetic datapath.

## Interface
- No parameters; widths are fixed by the shared package (16-bit word, 5-bit exponent, 10-bit fraction, bias 15).
- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high
- io_in_valid  input  1  operands valid
- io_in_ready  output  1  divider idle, can accept
- io_a  input  16  dividend, FP16
- io_b  input  16  divisor, FP16
- io_out_valid  output  1  result valid
- io_out_ready  input  1  consumer accepts result
- io_y  output  16  quotient, FP16

## Operation
- States: IDLE, DIVIDE, DONE.
  - IDLE: io_in_ready=1. On io_in_valid, latch operands and go to DIVIDE with iteration counter = 11.
  - DIVIDE: one quotient bit per cycle, counter 11 down to 0. After bit 0, go to DONE.
  - DONE: io_out_valid=1 and io_y stable until io_out_ready. Return to IDLE on the next cycle.
- Sign: a[15] ^ b[15].
- Exponent: 7-bit signed, e = a[14:10] − b[14:10] + 15.
- Significands: A = {1,a[9:0]}, D = {1,b[9:0]}.
- Restoring division: R starts at A. Each step: if R ≥ D then q[i]=1 and R −= D, else q[i]=0; then R <<= 1. This gives q = floor(A·2^11/D), with q in [2^10, 2^12).
- Normalize:
  - If q[11]=1: fraction = q[10:1].
  - Else: fraction = q[9:0] and e −= 1.
- Rounding: truncation only; the remainder is discarded.
- Range:
  - e ≥ 31 → signed infinity (0x7C00 | sign<<15).
  - e ≤ 0 → signed zero.
- Subnormal inputs (exponent 0, fraction ≠ 0) are treated as zero. Subnormal results are never produced.
- Zero precedence (always active): b zero → signed infinity; else a zero → signed zero. Both take the full latency.
- io_a and io_b are ignored outside the accept cycle.

## Timing
- Reset values: state IDLE, io_in_ready=1, io_out_valid=0, io_y=0x0000, all internal registers 0.
- Accept occurs in cycle 0, when io_in_valid && io_in_ready.
- DIVIDE occupies cycles 1–12.
- io_out_valid rises in cycle 13. Fixed latency of 13 cycles for every operand class, including specials.
- Output is held under backpressure; io_y does not change while io_out_valid && !io_out_ready.
- io_in_ready=0 from cycle 1 until the cycle after the output handshake. There is no accept in the DONE cycle.
- Minimum issue interval is 14 cycles.
- Reset asserted mid-operation: immediately IDLE, io_out_valid=0, io_y=0. The in-flight operation is discarded and not reported.

## Configuration
- FP16_DIV_SPECIALS_EN defined:
  - Either operand NaN → 0x7E00.
  - inf/inf or 0/0 → 0x7E00.
  - inf/finite → signed infinity.
  - finite/inf → signed zero.
  - These checks take precedence over the zero rules.
- Undefined:
  - Exponent 31 inputs are treated as ordinary normal numbers.
  - Only the zero-precedence rules apply, so 0/0 → signed infinity.
- Latency is identical in both builds.

## Structure
- Package fp16_pkg holds:
  - Constants: FP16_W, EXP_W, FRAC_W, BIAS=15, INF=0x7C00, QNAN=0x7E00.
  - A state enum typedef (IDLE, DIVIDE, DONE).
  - A classification typedef (zero, normal, inf, nan).
- Sub-module fp16_div_mant: the restoring-division datapath (R, D, q registers, step enable, counter), with a done pulse.
- The top level owns the FSM, sign/exponent path, special-case selection and output register.

## Test plan
- 0x3C00 / 0x4200 (1.0 / 3.0) → io_y=0x3555, io_out_valid exactly 13 cycles after accept.
- 0xC600 / 0x4000 (−6.0 / 2.0) → 0xC200. Then 0x3C00 / 0x4000 → 0x3800, issued back-to-back at the minimum 14-cycle interval.
- 0x3C00 / 0x0000 → 0x7C00. 0x8000 / 0x4000 → 0x8000. 0x7BFF / 0x0400 → 0x7C00 (overflow). 0x0400 / 0x7BFF → 0x0000 (underflow).
- Backpressure: hold io_out_ready=0 for 5 cycles after valid → io_y and io_out_valid stable, io_in_ready=0; released → handshake, then io_in_ready=1 next cycle.
- Reset pulse in cycle 6 of DIVIDE → outputs at reset values immediately; next operation 0x4200 / 0x3E00 → 0x4000.
- With FP16_DIV_SPECIALS_EN: 0x7E00 / 0x3C00 → 0x7E00; 0x7C00 / 0x7C00 → 0x7E00; 0x0000 / 0x0000 → 0x7E00. Without it: 0x0000 / 0x0000 → 0x7C00.
